// File: rtl/instr_fetch.sv
// Instruction fetch front end for a synchronous-read instruction memory.
// It drives the fetch address and tracks the one-cycle read latency with an
// inflight flag. Returned words go into a small FIFO, which presents
// {instr, pc} to decode over a valid/ready handshake. A redirect flushes
// every buffered and in-flight wrong-path fetch.
// Optional feature: define IFETCH_STALL_CNT_EN to add the perf_bubble_cnt
// output, a saturating count of clock edges where out_valid is low.
module instr_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [15:0]     r_fetch_pc;
  logic            r_inflight;
  logic [15:0]     r_pc_q;
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [31:0]     r_mem_instr [BUF_DEPTH];
  logic [15:0]     r_mem_pc    [BUF_DEPTH];

  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [OccW-1:0] w_occ;
  logic            w_unused_bits;

  // Low address bits of a redirect target are ignored (word-aligned fetch).
  assign w_unused_bits = ^redirect_pc[1:0];

  assign imem_addr = r_fetch_pc;

  // Handshake and issue decisions. A redirect blocks pop, push and issue.
  always_comb begin
    out_valid = (r_count != '0) && !redirect_valid;
    w_pop     = out_valid && out_ready;
    w_push    = r_inflight && !redirect_valid;
    // Occupancy after this edge, counting the in-flight word; pop implies
    // count >= 1, so this never underflows.
    w_occ     = OccW'(r_count) + OccW'(r_inflight) - OccW'(w_pop);
    w_issue   = !redirect_valid && (w_occ < OccW'(BUF_DEPTH));
  end

  // The head entry drives decode directly, so it stays stable while stalled.
  always_comb begin
    out_instr = r_mem_instr[r_rd_ptr];
    out_pc    = r_mem_pc[r_rd_ptr];
  end

  // Fetch address, inflight tracking and the pc of the outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_pc_q     <= 16'h0000;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[15:2], 2'b00};
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + 16'd4;
      r_inflight <= 1'b1;
      r_pc_q     <= r_fetch_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (redirect_valid) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage. It is cleared on reset so the head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        r_mem_instr[i] <= 32'h0;
        r_mem_pc[i]    <= 16'h0;
      end
    end else if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_pc_q;
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Count decode-side bubbles and saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= 32'h0;
    end else if (!out_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule
